// File: rtl/alu_exec_unit_pkg.sv
// Shared types for the ALU execution unit: ALU op encoding, responder FSM
// states, response record, and the shift-op classifier.
package alu_exec_unit_pkg;

  localparam int ALU_N = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10
  } alu_control_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_exec_state_t;

  typedef struct packed {
    logic [ALU_N-1:0] result;
    logic             overflow;
    logic             zero;
    logic             equal;
  } alu_rsp_t;

  function automatic logic is_shift_op(alu_control_t c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU.
// Ports: a, b (operands), control (op select) -> result, overflow
// (signed wrap on ADD/SUB only). Shift amount is b[SHAMT_W-1:0].
module alu
  import alu_exec_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  alu_control_t  control,
  output logic [N-1:0]  result,
  output logic          overflow
);
  localparam int SHAMT_W = $clog2(N);

  logic [SHAMT_W-1:0] shamt;
  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control)
      ALU_ADD: begin
        result   = a + b;
        overflow = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
      end
      ALU_SUB: begin
        result   = a - b;
        overflow = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(N-1){1'b0}}, (a < b)};
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/alu_exec_unit_shift_iter.sv
// Iterative shifter, one bit per clock.
// Ports: clk, rst (async active-low), start (load a/shamt/control),
// control (SLL/SRL/SRA), a, shamt -> done (high on the cycle whose edge
// takes the count 1->0), result (work value after this cycle's shift).
module alu_shift_iter
  import alu_exec_unit_pkg::*;
#(
  parameter int N       = 32,
  parameter int SHAMT_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  alu_control_t       control,
  input  logic [N-1:0]       a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               done,
  output logic [N-1:0]       result
);
  logic [N-1:0]       work_q;
  logic [SHAMT_W-1:0] cnt_q;
  alu_control_t       op_q;
  logic               fill;

  // SRA replicates the sign bit; SLL/SRL shift in zeros.
  assign fill = (op_q == ALU_SRA) ? work_q[N-1] : 1'b0;

  always_comb begin
    if (op_q == ALU_SLL) result = {work_q[N-2:0], 1'b0};
    else                 result = {fill, work_q[N-1:1]};
  end

  assign done = (cnt_q == SHAMT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      op_q   <= ALU_SLL;
    end else if (start) begin
      work_q <= a;
      cnt_q  <= shamt;
      op_q   <= control;
    end else if (cnt_q != '0) begin
      work_q <= result;
      cnt_q  <= cnt_q - SHAMT_W'(1);
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// Valid/ready responder around the combinational ALU.
// Ports: clk, rst (async active-low); request req_valid/req_ready/req_a/
// req_b/req_control; response rsp_valid/rsp_ready/rsp_result/rsp_overflow/
// rsp_zero/rsp_equal; busy (FSM not IDLE).
// Config macro ALU_EXEC_FAST_SHIFT_EN: shifts go through the combinational
// ALU (1-cycle latency, no SHIFT state/counter). Default: iterative shifter.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int N       = 32,
  parameter int SHAMT_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  input  alu_control_t req_control,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_overflow,
  output logic         rsp_zero,
  output logic         rsp_equal,
  output logic         busy
);
  alu_exec_state_t state_q, state_d;
  alu_rsp_t        rsp_q;
  logic [N-1:0]    alu_result;
  logic            alu_ovf;
  logic            accept;
  logic            shift_start;

  alu #(.N(N)) u_alu (
    .a        (req_a),
    .b        (req_b),
    .control  (req_control),
    .result   (alu_result),
    .overflow (alu_ovf)
  );

  // Accept-on-drain: DONE takes a new request on the same edge the
  // response leaves, so back-to-back ops see no bubble.
  assign req_ready = rst && ((state_q == IDLE) || ((state_q == DONE) && rsp_ready));
  assign accept    = req_valid && req_ready;

`ifdef ALU_EXEC_FAST_SHIFT_EN
  assign shift_start = 1'b0;
`else
  logic         shift_done;
  logic [N-1:0] shift_result;
  logic         eq_pend_q;

  // Shift by zero bypasses the iterator and completes like any other op.
  assign shift_start = accept && is_shift_op(req_control) &&
                       (req_b[SHAMT_W-1:0] != '0);

  alu_shift_iter #(.N(N), .SHAMT_W(SHAMT_W)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .start   (shift_start),
    .control (req_control),
    .a       (req_a),
    .shamt   (req_b[SHAMT_W-1:0]),
    .done    (shift_done),
    .result  (shift_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        eq_pend_q <= 1'b0;
    else if (accept) eq_pend_q <= (req_a == req_b);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = shift_start ? SHIFT : DONE;
`ifndef ALU_EXEC_FAST_SHIFT_EN
      SHIFT: if (shift_done) state_d = DONE;
`endif
      DONE: begin
        if (accept)         state_d = shift_start ? SHIFT : DONE;
        else if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_q <= '0;
    end else if (accept && !shift_start) begin
      rsp_q.result   <= alu_result;
      rsp_q.overflow <= alu_ovf;
      rsp_q.zero     <= (alu_result == '0);
      rsp_q.equal    <= (req_a == req_b);
    end
`ifndef ALU_EXEC_FAST_SHIFT_EN
    else if ((state_q == SHIFT) && shift_done) begin
      rsp_q.result   <= shift_result;
      rsp_q.overflow <= 1'b0;
      rsp_q.zero     <= (shift_result == '0);
      rsp_q.equal    <= eq_pend_q;
    end
`endif
  end

  assign rsp_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign rsp_result   = rsp_q.result;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_equal    = rsp_q.equal;
endmodule
